// File: rtl/lif_neuron_update.sv
// Leaky integrate-and-fire membrane stage fed by the signed Q-point adder.
// Ports: clk, rst (async high), in_valid/in_ready/in_current, step_i,
//   spike_o, done_o, v_mem_o, refrac_o. Macro LIF_REFRAC_EN enables the
//   refractory counter; undefined ties refrac_o low.
module lif_neuron_update #(
  parameter int DATA_WIDTH = 16,
  parameter int FRAC_BITS = 8,
  parameter int ACC_GUARD = 4,
  parameter logic signed [DATA_WIDTH-1:0] THRESHOLD = 16'sh0100,
  parameter logic signed [DATA_WIDTH-1:0] V_RESET = 16'sh0000,
  parameter int LEAK_SHIFT = 2,
  parameter int REFRAC_STEPS = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic in_valid,
  output logic in_ready,
  input  logic signed [DATA_WIDTH-1:0] in_current,
  input  logic step_i,
  output logic spike_o,
  output logic done_o,
  output logic signed [DATA_WIDTH-1:0] v_mem_o,
  output logic refrac_o
);

  localparam int DW = DATA_WIDTH;
  localparam int AW = DATA_WIDTH + ACC_GUARD;
  localparam int VW = AW + 2;

  localparam logic signed [AW-1:0] ACC_MAX = {1'b0, {(AW-1){1'b1}}};
  localparam logic signed [AW-1:0] ACC_MIN = {1'b1, {(AW-1){1'b0}}};
  localparam logic signed [DW-1:0] V_MAX = {1'b0, {(DW-1){1'b1}}};
  localparam logic signed [DW-1:0] V_MIN = {1'b1, {(DW-1){1'b0}}};

  typedef enum logic {
    ACCUM,
    UPDATE
  } state_t;

  state_t state;
  logic signed [AW-1:0] acc;
  logic signed [DW-1:0] v_mem;

  logic signed [AW:0] acc_sum;
  logic signed [AW-1:0] acc_sat;
  logic signed [DW-1:0] leak;
  logic signed [VW-1:0] v_wide;
  logic [VW-DW:0] v_hi;
  logic signed [DW-1:0] v_sat;
  logic fire;
  logic refrac;

  assign in_ready = (state == ACCUM);
  assign v_mem_o = v_mem;

  // One extra bit catches overflow of the guarded accumulator.
  assign acc_sum = {acc[AW-1], acc}
                 + {{(ACC_GUARD+1){in_current[DW-1]}}, in_current};

  always_comb begin
    acc_sat = acc_sum[AW-1:0];
    if (acc_sum[AW] != acc_sum[AW-1])
      acc_sat = acc_sum[AW] ? ACC_MIN : ACC_MAX;
  end

  assign leak = v_mem >>> LEAK_SHIFT;

  assign v_wide = {{(VW-DW){v_mem[DW-1]}}, v_mem}
                - {{(VW-DW){leak[DW-1]}}, leak}
                + {{2{acc[AW-1]}}, acc};

  // Fits in DW bits only if all bits above the DW sign bit agree.
  assign v_hi = v_wide[VW-1:DW-1];

  always_comb begin
    v_sat = v_wide[DW-1:0];
    if (!(&v_hi || ~|v_hi))
      v_sat = v_wide[VW-1] ? V_MIN : V_MAX;
  end

  assign fire = (v_sat >= THRESHOLD);

`ifdef LIF_REFRAC_EN
  localparam int CW =
    (REFRAC_STEPS > 0) ? $clog2(REFRAC_STEPS + 1) : 1;

  logic [CW-1:0] cnt;

  assign refrac = (cnt != '0);
  assign refrac_o = refrac;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (state == UPDATE) begin
      if (refrac)
        cnt <= cnt - 1'b1;
      else if (fire)
        cnt <= CW'(REFRAC_STEPS);
    end
  end
`else
  assign refrac = 1'b0;
  assign refrac_o = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ACCUM;
      acc <= '0;
      v_mem <= '0;
      spike_o <= 1'b0;
      done_o <= 1'b0;
    end else begin
      spike_o <= 1'b0;
      done_o <= 1'b0;
      unique case (state)
        ACCUM: begin
          if (in_valid)
            acc <= acc_sat;
          if (step_i)
            state <= UPDATE;
        end
        UPDATE: begin
          acc <= '0;
          done_o <= 1'b1;
          state <= ACCUM;
          if (refrac) begin
            v_mem <= V_RESET;
          end else if (fire) begin
            v_mem <= V_RESET;
            spike_o <= 1'b1;
          end else begin
            v_mem <= v_sat;
          end
        end
        default: state <= ACCUM;
      endcase
    end
  end

endmodule

// File: tb/tb_lif_neuron_update.sv
// Scoreboard bench for lif_neuron_update: directed scenarios plus random
// traffic, checked against an integer model of the membrane rules.
module tb_lif_neuron_update;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic in_valid = 1'b0;
  logic step_i = 1'b0;
  logic [15:0] in_current = '0;
  logic in_ready;
  logic spike_o;
  logic done_o;
  logic [15:0] v_mem_o;
  logic refrac_o;

  always #5 clk = ~clk;

  lif_neuron_update dut (
    .clk(clk),
    .rst(rst),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_current(in_current),
    .step_i(step_i),
    .spike_o(spike_o),
    .done_o(done_o),
    .v_mem_o(v_mem_o),
    .refrac_o(refrac_o)
  );

`ifdef LIF_REFRAC_EN
  localparam int REF_STEPS = 2;
`else
  localparam int REF_STEPS = 0;
`endif

  typedef struct {
    int v;
    int spike;
    int refrac;
  } exp_t;

  exp_t q[$];

  int passed = 0;
  int total = 0;

  int m_acc = 0;
  int m_v = 0;
  int m_ref = 0;
  bit m_bubble = 0;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  function automatic int clamp(input int x, input int lo, input int hi);
    if (x < lo) return lo;
    if (x > hi) return hi;
    return x;
  endfunction

  task automatic model_step();
    exp_t e;
    int vn;
    e.spike = 0;
    if (m_ref > 0) begin
      m_ref--;
      m_v = 0;
    end else begin
      vn = clamp(m_v - (m_v >>> 2) + m_acc, -32768, 32767);
      if (vn >= 256) begin
        m_v = 0;
        e.spike = 1;
        m_ref = REF_STEPS;
      end else begin
        m_v = vn;
      end
    end
    m_acc = 0;
    e.v = m_v;
    e.refrac = (m_ref != 0) ? 1 : 0;
    q.push_back(e);
  endtask

  task automatic cycle(input bit v, input logic [15:0] d, input bit s,
                       output bit ok);
    int x;
    @(negedge clk);
    in_valid = v;
    in_current = d;
    step_i = s;
    check("in_ready", int'(in_ready), m_bubble ? 0 : 1);
    @(posedge clk);
    if (m_bubble) begin
      m_bubble = 0;
      ok = 0;
    end else begin
      ok = 1;
      if (v) begin
        x = int'($signed(d));
        m_acc = clamp(m_acc + x, -524288, 524287);
      end
      if (s) begin
        model_step();
        m_bubble = 1;
      end
    end
  endtask

  task automatic send(input bit v, input logic [15:0] d, input bit s);
    bit ok;
    int tries;
    tries = 0;
    do begin
      cycle(v, d, s, ok);
      tries++;
    end while (!ok && tries < 3);
    if (!ok) check("accept_timeout", 0, 1);
  endtask

  task automatic idle(input int n);
    bit ok;
    for (int i = 0; i < n; i++) cycle(0, 16'h0, 0, ok);
  endtask

  task automatic do_reset();
    @(negedge clk);
    in_valid = 0;
    step_i = 0;
    rst = 1;
    #1;
    check("rst_v_mem", int'(v_mem_o), 0);
    check("rst_spike", int'(spike_o), 0);
    check("rst_done", int'(done_o), 0);
    check("rst_refrac", int'(refrac_o), 0);
    q.delete();
    m_acc = 0;
    m_v = 0;
    m_ref = 0;
    m_bubble = 0;
    @(negedge clk);
    rst = 0;
    #1;
    check("rst_ready", int'(in_ready), 1);
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (done_o) begin
        if (q.size() == 0) begin
          check("unexpected_done", 1, 0);
        end else begin
          exp_t e;
          e = q.pop_front();
          check("v_mem", int'($signed(v_mem_o)), e.v);
          check("spike", int'(spike_o), e.spike);
          check("refrac", int'(refrac_o), e.refrac);
        end
      end else begin
        check("spike_no_done", int'(spike_o), 0);
      end
    end
  end

  initial begin
    bit ok;
    repeat (2) @(negedge clk);
    check("init_v_mem", int'(v_mem_o), 0);
    check("init_done", int'(done_o), 0);
    rst = 0;

    // reset mid-ACCUM with pending current
    send(1, 16'h0040, 0);
    send(1, 16'h0040, 0);
    do_reset();
    send(0, 16'h0, 1);
    idle(2);

    // sub-threshold then leak
    send(1, 16'h0040, 0);
    send(1, 16'h0040, 0);
    send(0, 16'h0, 1);
    idle(2);
    send(0, 16'h0, 1);
    idle(2);

    // reset during UPDATE with non-zero membrane
    send(0, 16'h0, 1);
    do_reset();
    idle(1);

    // fire, then refractory steps
    send(1, 16'h0080, 0);
    send(1, 16'h0090, 0);
    send(0, 16'h0, 1);
    idle(2);
    for (int i = 0; i < 3; i++) begin
      send(1, 16'h0200, 0);
      send(0, 16'h0, 1);
      idle(2);
    end

    // positive saturation
    for (int i = 0; i < 20; i++) send(1, 16'h7fff, 0);
    send(0, 16'h0, 1);
    idle(2);
    send(0, 16'h0, 1);
    send(0, 16'h0, 1);
    idle(2);

    // negative saturation
    for (int i = 0; i < 4; i++) send(1, 16'h8000, 0);
    send(0, 16'h0, 1);
    idle(2);

    // input with step, then input held across UPDATE
    send(1, 16'h0010, 1);
    send(1, 16'h0020, 0);
    send(0, 16'h0, 1);
    idle(2);

    // random traffic
    for (int i = 0; i < 500; i++) begin
      logic [15:0] d;
      bit v;
      bit s;
      v = ($urandom % 3) != 0;
      if (($urandom % 4) == 0) d = 16'($urandom);
      else d = 16'($signed($urandom_range(0, 512)) - 256);
      s = ($urandom % 6) == 0;
      cycle(v, d, s, ok);
    end
    idle(4);
    check("queue_drained", q.size(), 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/lif_neuron_update.md
# lif_neuron_update

Leaky integrate-and-fire membrane stage sitting directly downstream of the signed Q-point adder in the MAC path. Each incoming adder result is one partial synaptic current. During a timestep the block accumulates these currents with saturation. On a timestep strobe it applies leak, integrates, thresholds, emits a spike and enforces a refractory period. All arithmetic is signed two's complement in the same Q format as the adder output (FRAC_BITS fractional bits).

## Interface
Parameters:
- DATA_WIDTH, 16: width of `in_current` and `v_mem`; equals the adder OUT_WIDTH.
- FRAC_BITS, 8: fractional bits of every signed quantity. Informational only; the datapath is format-agnostic.
- ACC_GUARD, 4: guard bits in the timestep accumulator. ACC_WIDTH = DATA_WIDTH + ACC_GUARD.
- THRESHOLD, 16'sh0100: firing threshold (1.0 in Q8.8). A spike occurs when v_next >= THRESHOLD.
- V_RESET, 16'sh0000: membrane value loaded after a spike.
- LEAK_SHIFT, 2: leak term = v_mem >>> LEAK_SHIFT (arithmetic shift, floors toward -inf).
- REFRAC_STEPS, 2: timesteps held in refractory after a spike. 0 disables the period.

Ports:
- clk, in, 1: rising-edge clock.
- rst, in, 1: asynchronous, active-high reset.
- in_valid, in, 1: `in_current` is valid.
- in_ready, out, 1: the block accepts input; equals (state == ACCUM).
- in_current, in, DATA_WIDTH signed: partial current from the adder.
- step_i, in, 1: end-of-timestep strobe; sampled only in ACCUM.
- spike_o, out, 1: one-cycle spike pulse.
- done_o, out, 1: one-cycle pulse marking a completed timestep update, whether or not a spike occurred.
- v_mem_o, out, DATA_WIDTH signed: registered membrane potential.
- refrac_o, out, 1: refractory counter is non-zero.

## Operation
- States: ACCUM and UPDATE.
- ACCUM:
  - Each in_valid && in_ready adds sign-extended `in_current` to `acc`, saturating at ±ACC_WIDTH limits.
  - If step_i is high in ACCUM, any input accepted in the same cycle is included in this timestep's acc. Next state is UPDATE.
- UPDATE lasts exactly one cycle, with in_ready = 0:
  - Not refractory: v_next = v_mem − (v_mem >>> LEAK_SHIFT) + acc. Compute at ACC_WIDTH+2 bits, then saturate to DATA_WIDTH.
    - If v_next >= THRESHOLD: v_mem <= V_RESET, spike_o <= 1, counter <= REFRAC_STEPS.
    - Otherwise: v_mem <= v_next.
  - Refractory (counter != 0): acc is discarded, v_mem holds V_RESET, counter decrements, no spike.
  - In all cases: acc <= 0, done_o <= 1, next state is ACCUM.
- step_i is ignored in UPDATE; it is not queued.
- An in_valid held across UPDATE stalls and is accepted in the following ACCUM cycle, into the next timestep.
- Reset (asynchronous, at any time including mid-UPDATE):
  - state = ACCUM, acc = 0, v_mem_o = 0, counter = 0.
  - spike_o = 0, done_o = 0, refrac_o = 0.
  - in_ready = 1 once rst deasserts.

## Timing
- step_i accepted at edge t. UPDATE occupies cycle t+1. spike_o, done_o and the new v_mem_o are visible during cycle t+2, and the block is back in ACCUM in that cycle.
- Minimum spacing between steps is 2 cycles.
- Input throughput is 1 per cycle in ACCUM, with a one-cycle bubble per timestep.
- spike_o and done_o are high for exactly one cycle per update.
- No combinational path from in_current to any output.

## Configuration
- LIF_REFRAC_EN:
  - Defined: refractory counter and refrac_o are implemented as described above.
  - Undefined: the counter is removed, REFRAC_STEPS is ignored, refrac_o is tied to 0, and the neuron may fire on every step.

## Test plan
Defaults unless stated; REFRAC_STEPS=2; LIF_REFRAC_EN defined.
1. Reset:
   - Stimulus: assert rst mid-ACCUM after inputs 0x0040, 0x0040.
   - Expect: all outputs 0 immediately. After release, step with no input gives v_mem_o = 0 and no spike.
2. Sub-threshold and leak:
   - Stimulus: inputs 0x0040, 0x0040, then step. Then a step with no input.
   - Expect: first step v_mem_o = 0x0080, spike_o = 0. Second step v_mem_o = 0x0060.
3. Fire:
   - Stimulus: inputs 0x0080, 0x0090, then step at t.
   - Expect: spike_o = 1 and done_o = 1 at t+2 only, v_mem_o = 0x0000, refrac_o = 1.
4. Refractory:
   - Stimulus: after scenario 3, two steps each preceded by input 0x0200, then a third step with input 0x0200.
   - Expect: first two steps give no spike, v_mem_o = 0, refrac_o clears after the second. Third step spikes.
   - Repeat with LIF_REFRAC_EN undefined: expect a spike on every step.
5. Saturation, positive:
   - Stimulus: 20 inputs of 0x7FFF, then step.
   - Expect: acc clamps to 0x7FFFF, v_mem_o path saturates to 0x7FFF, spike_o = 1.
6. Saturation, negative:
   - Stimulus: 4 inputs of 0x8000, then step.
   - Expect: v_mem_o = 0x8000, no spike.
7. Simultaneous events:
   - Stimulus: in_valid with 0x0010 in the same cycle as step_i; then in_valid with 0x0020 held through UPDATE.
   - Expect: 0x0010 is counted in the current step. 0x0020 stalls one cycle (in_ready = 0) and lands in the next step.
